// File: rtl/ssm_decap.sv
// Strips outer MD0/MD1/ETH-hdr2 from FAST-hdr2 packets, restores inner MD0 as head, recovers 5-tuple.
// Latency 2 edges per word, tail flushed one edge after it is sampled; no backpressure, malformed packets dropped.
module ssm_decap #(
    parameter PLATFORM = "Xilinx-OpenBox-S4"
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] pktin_decap_data,
    input  logic         pktin_decap_data_wr,
    output logic [133:0] pktout_decap_data,
    output logic         pktout_decap_data_wr,
    output logic [103:0] tuple_out,
    output logic         tuple_out_valid,
    output logic [15:0]  drop_cnt,
    output logic [15:0]  len_err_cnt
);

    if (PLATFORM != "Xilinx-OpenBox-S4") begin : g_other_platform
    end

    localparam logic [1:0]  FLAG_HEAD = 2'b01;
    localparam logic [1:0]  FLAG_MID  = 2'b11;
    localparam logic [1:0]  FLAG_TAIL = 2'b10;
    localparam logic [15:0] ETH_HDR2  = 16'hff03;

    typedef enum logic [2:0] {
        IDLE_S,
        STRIP_MD1_S,
        CHECK_ETH_S,
        INNER_MD0_S,
        INNER_MD1_S,
        TRAN_S,
        FLUSH_S,
        DISCARD_S
    } state_t;

    state_t         state, state_nxt;
    logic [133:0]   hold_reg, hold_nxt;
    logic [11:0]    outer_len, len_nxt;
    logic [133:0]   out_dat_nxt;
    logic           out_wr_nxt;
    logic [103:0]   tuple_nxt;
    logic           tuple_vld_nxt;
    logic           drop_inc;
    logic           len_err_inc;

    logic [1:0]     flag;
    logic           wr;
    logic           is_head;
    logic           is_tail;

    assign flag    = pktin_decap_data[133:132];
    assign wr      = pktin_decap_data_wr;
    assign is_head = wr && (flag == FLAG_HEAD);
    assign is_tail = wr && (flag == FLAG_TAIL);

    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold_reg;
        len_nxt       = outer_len;
        out_dat_nxt   = '0;
        out_wr_nxt    = 1'b0;
        tuple_nxt     = tuple_out;
        tuple_vld_nxt = 1'b0;
        drop_inc      = 1'b0;
        len_err_inc   = 1'b0;
        case (state)
            IDLE_S: begin
                if (is_head) begin
                    len_nxt   = pktin_decap_data[107:96];
                    state_nxt = STRIP_MD1_S;
                end
            end
            STRIP_MD1_S: begin
                if (wr) begin
                    if (flag == FLAG_MID) begin
                        state_nxt = CHECK_ETH_S;
                    end else begin
                        drop_inc = 1'b1;
                        // a fresh head restarts the strip on the new packet
                        if (flag == FLAG_HEAD) begin
                            len_nxt = pktin_decap_data[107:96];
                        end else begin
                            state_nxt = IDLE_S;
                        end
                    end
                end
            end
            CHECK_ETH_S: begin
                if (wr) begin
                    if (flag == FLAG_MID && pktin_decap_data[31:16] == ETH_HDR2) begin
                        state_nxt = INNER_MD0_S;
                    end else begin
                        drop_inc  = 1'b1;
                        state_nxt = (flag == FLAG_TAIL) ? IDLE_S : DISCARD_S;
                    end
                end
            end
            INNER_MD0_S: begin
                if (is_tail) begin
                    drop_inc  = 1'b1;
                    state_nxt = IDLE_S;
                end else if (wr) begin
                    hold_nxt  = {FLAG_HEAD, pktin_decap_data[131:0]};
                    if (pktin_decap_data[107:96] != outer_len - 12'd48) begin
                        len_err_inc = 1'b1;
                    end
                    state_nxt = INNER_MD1_S;
                end
            end
            INNER_MD1_S: begin
                if (is_tail) begin
                    drop_inc  = 1'b1;
                    state_nxt = IDLE_S;
                end else if (wr) begin
                    out_dat_nxt   = hold_reg;
                    out_wr_nxt    = 1'b1;
                    tuple_nxt     = pktin_decap_data[103:0];
                    tuple_vld_nxt = 1'b1;
                    hold_nxt      = {FLAG_MID, pktin_decap_data[131:128], 128'b0};
                    state_nxt     = TRAN_S;
                end
            end
            TRAN_S: begin
                if (wr) begin
                    out_dat_nxt = hold_reg;
                    out_wr_nxt  = 1'b1;
                    hold_nxt    = pktin_decap_data;
                    if (flag == FLAG_TAIL) begin
                        state_nxt = FLUSH_S;
                    end
                end
            end
            FLUSH_S: begin
                out_dat_nxt = hold_reg;
                out_wr_nxt  = 1'b1;
                if (is_head) begin
                    len_nxt   = pktin_decap_data[107:96];
                    state_nxt = STRIP_MD1_S;
                end else begin
                    state_nxt = IDLE_S;
                end
            end
            DISCARD_S: begin
                if (is_tail) begin
                    state_nxt = IDLE_S;
                end
            end
            default: state_nxt = IDLE_S;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE_S;
            hold_reg             <= '0;
            outer_len            <= '0;
            pktout_decap_data    <= '0;
            pktout_decap_data_wr <= 1'b0;
            tuple_out            <= '0;
            tuple_out_valid      <= 1'b0;
            drop_cnt             <= '0;
            len_err_cnt          <= '0;
        end else begin
            state                <= state_nxt;
            hold_reg             <= hold_nxt;
            outer_len            <= len_nxt;
            pktout_decap_data    <= out_dat_nxt;
            pktout_decap_data_wr <= out_wr_nxt;
            tuple_out            <= tuple_nxt;
            tuple_out_valid      <= tuple_vld_nxt;
            if (drop_inc && drop_cnt != 16'hffff) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (len_err_inc && len_err_cnt != 16'hffff) begin
                len_err_cnt <= len_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ssm_decap.sv
// Directed bench for ssm_decap: packet-level reference model plus per-cycle output compare.
module tb_ssm_decap;

    typedef logic [133:0] word_t;

    logic         clk;
    logic         rst_n;
    word_t        din;
    logic         din_wr;
    word_t        dout;
    logic         dout_wr;
    logic [103:0] tup;
    logic         tup_vld;
    logic [15:0]  drop_cnt;
    logic [15:0]  len_err_cnt;

    ssm_decap #(.PLATFORM("Xilinx-OpenBox-S4")) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pktin_decap_data     (din),
        .pktin_decap_data_wr  (din_wr),
        .pktout_decap_data    (dout),
        .pktout_decap_data_wr (dout_wr),
        .tuple_out            (tup),
        .tuple_out_valid      (tup_vld),
        .drop_cnt             (drop_cnt),
        .len_err_cnt          (len_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    bit mon_en = 1'b0;
    int tup_pulses = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    word_t        exp_q[$];
    logic [103:0] exp_tup_q[$];
    int           exp_drop   = 0;
    int           exp_lenerr = 0;

    word_t        log_dat[$];
    int           log_cyc[$];

    word_t        pkt[$];
    word_t        m_out[$];
    logic [103:0] m_tup;
    bit           m_has_tup;
    int           m_drop;
    int           m_lenerr;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Packet-level rules: short or wrong-EtherType packets vanish; good ones lose
    // three words, with the inner MD0 re-flagged as head and w4 replaced by a blank MD1.
    task automatic model_pkt(input word_t p[$]);
        int    n;
        word_t w;
        n = p.size();
        m_out.delete();
        m_drop    = 0;
        m_lenerr  = 0;
        m_has_tup = 1'b0;
        m_tup     = '0;
        if (n < 6 || p[2][31:16] != 16'hff03) begin
            m_drop = 1;
        end else begin
            if (p[3][107:96] != 12'(p[0][107:96] - 12'd48)) m_lenerr = 1;
            w = p[3];
            w[133:132] = 2'b01;
            m_out.push_back(w);
            w = '0;
            w[133:132] = 2'b11;
            w[131:128] = p[4][131:128];
            m_out.push_back(w);
            for (int k = 5; k < n; k++) m_out.push_back(p[k]);
            m_tup     = p[4][103:0];
            m_has_tup = 1'b1;
        end
    endtask

    task automatic expect_pkt();
        foreach (m_out[i]) exp_q.push_back(m_out[i]);
        if (m_has_tup) exp_tup_q.push_back(m_tup);
        exp_drop   += m_drop;
        exp_lenerr += m_lenerr;
    endtask

    task automatic make_pkt(input int n, input logic [11:0] olen, input logic [11:0] ilen,
                            input logic [15:0] eth, input int seed);
        word_t w;
        pkt.delete();
        for (int k = 0; k < n; k++) begin
            w = '0;
            w[127:0]   = {8{16'(seed * 256 + k)}};
            w[133:132] = 2'b11;
            case (k)
                0: begin w[133:132] = 2'b01; w[107:96] = olen; end
                2: w[31:16] = eth;
                3: w[107:96] = ilen;
                default: ;
            endcase
            if (k == n - 1) begin
                w[133:132] = 2'b10;
                w[131:128] = 4'h5;
            end
            pkt.push_back(w);
        end
    endtask

    task automatic cyc(input word_t d, input logic w);
        din    = d;
        din_wr = w;
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input word_t p[$], input int gap_after, input int gap_len);
        for (int k = 0; k < p.size(); k++) begin
            cyc(p[k], 1'b1);
            if (k == gap_after) repeat (gap_len) cyc('0, 1'b0);
        end
    endtask

    task automatic drain();
        repeat (3) cyc('0, 1'b0);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc('0, 1'b0);
        chk("drain_pending", exp_q.size() + exp_tup_q.size(), 0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_drop_cnt"}, drop_cnt, exp_drop);
        chk({tag, "_len_err_cnt"}, len_err_cnt, exp_lenerr);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_wr) begin
                log_dat.push_back(dout);
                log_cyc.push_back(cyc_n);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", dout);
                end else begin
                    chk("out_word", dout, exp_q.pop_front());
                end
            end else begin
                chk("idle_data_zero", dout, '0);
            end
            if (tup_vld) begin
                tup_pulses++;
                chk("tuple_head_align", {dout_wr, dout[133:132]}, 3'b101);
                if (exp_tup_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tuple actual=%h required=none", tup);
                end else begin
                    chk("tuple_out", tup, exp_tup_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int    base;
        int    t0;
        int    pulses0;
        word_t pa[$];
        int    gap_off[5];

        rst_n  = 1'b0;
        din    = '0;
        din_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", dout, '0);
        chk("rst_wr", dout_wr, 0);
        chk("rst_tuple", tup, '0);
        chk("rst_tuple_valid", tup_vld, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_len_err_cnt", len_err_cnt, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cyc('0, 1'b0);

        // good 8-word packet
        make_pkt(8, 12'd112, 12'd64, 16'hff03, 1);
        model_pkt(pkt);
        expect_pkt();
        base    = log_dat.size();
        pulses0 = tup_pulses;
        t0      = cyc_n + 1;
        send_words(pkt, -1, 0);
        drain();
        chk("t1_word_count", log_dat.size() - base, 5);
        if (log_dat.size() - base >= 5) begin
            chk("t1_head_flag_len", {log_dat[base][133:132], log_dat[base][107:96]}, {2'b01, 12'd64});
            chk("t1_md1", log_dat[base + 1], {2'b11, 4'h0, 128'b0});
            chk("t1_tail", log_dat[base + 4], pkt[7]);
            chk("t1_head_latency", log_cyc[base] - t0, 4);
            for (int k = 1; k < 5; k++) chk("t1_back_to_back", log_cyc[base + k] - log_cyc[base], k);
        end
        chk("t1_tuple_pulses", tup_pulses - pulses0, 1);
        chk("t1_tuple_hold", tup, pkt[4][103:0]);
        chk("t1_drop_lit", drop_cnt, 0);
        chk("t1_lenerr_lit", len_err_cnt, 0);
        chk_counters("t1");

        // wrong EtherType, then a good packet
        make_pkt(8, 12'd112, 12'd64, 16'h0800, 2);
        model_pkt(pkt);
        expect_pkt();
        base = log_dat.size();
        send_words(pkt, -1, 0);
        drain();
        chk("t2_no_output", log_dat.size() - base, 0);
        chk("t2_drop_lit", drop_cnt, 1);
        chk_counters("t2");
        make_pkt(8, 12'd112, 12'd64, 16'hff03, 3);
        model_pkt(pkt);
        expect_pkt();
        base = log_dat.size();
        send_words(pkt, -1, 0);
        drain();
        chk("t2_next_count", log_dat.size() - base, 5);
        chk_counters("t2b");

        // inner length mismatch still forwarded
        make_pkt(8, 12'd112, 12'd70, 16'hff03, 4);
        model_pkt(pkt);
        expect_pkt();
        base = log_dat.size();
        send_words(pkt, -1, 0);
        drain();
        chk("t3_count", log_dat.size() - base, 5);
        chk("t3_lenerr_lit", len_err_cnt, 1);
        chk_counters("t3");

        // back-to-back, second head lands in the flush cycle
        make_pkt(8, 12'd112, 12'd64, 16'hff03, 5);
        model_pkt(pkt);
        expect_pkt();
        pa = pkt;
        make_pkt(8, 12'd112, 12'd64, 16'hff03, 6);
        model_pkt(pkt);
        expect_pkt();
        base = log_dat.size();
        send_words(pa, -1, 0);
        send_words(pkt, -1, 0);
        drain();
        chk("t4_count", log_dat.size() - base, 10);
        if (log_dat.size() - base >= 10) begin
            chk("t4_first_tail", log_dat[base + 4], pa[7]);
            chk("t4_second_head", log_dat[base + 5][133:132], 2'b01);
        end
        chk_counters("t4");

        // 4-word short packet, then a good packet with a 2-cycle input gap after w5
        make_pkt(4, 12'd112, 12'd64, 16'hff03, 7);
        model_pkt(pkt);
        expect_pkt();
        base = log_dat.size();
        send_words(pkt, -1, 0);
        drain();
        chk("t5_short_no_output", log_dat.size() - base, 0);
        chk("t5_drop_lit", drop_cnt, 2);
        make_pkt(8, 12'd112, 12'd64, 16'hff03, 8);
        model_pkt(pkt);
        expect_pkt();
        base = log_dat.size();
        send_words(pkt, 5, 2);
        drain();
        chk("t5_gap_count", log_dat.size() - base, 5);
        gap_off = '{0, 1, 4, 5, 6};
        if (log_dat.size() - base >= 5) begin
            for (int k = 1; k < 5; k++) chk("t5_gap_timing", log_cyc[base + k] - log_cyc[base], gap_off[k]);
        end
        chk_counters("t5");

        // reset during w5: only the head already emitted survives
        make_pkt(8, 12'd112, 12'd64, 16'hff03, 9);
        model_pkt(pkt);
        exp_q.push_back(m_out[0]);
        exp_tup_q.push_back(m_tup);
        base = log_dat.size();
        for (int k = 0; k < 5; k++) cyc(pkt[k], 1'b1);
        rst_n = 1'b0;
        cyc(pkt[5], 1'b1);
        rst_n = 1'b1;
        exp_drop   = 0;
        exp_lenerr = 0;
        chk("t6_rst_data", dout, '0);
        chk("t6_rst_wr", dout_wr, 0);
        chk("t6_rst_tuple", tup, '0);
        chk("t6_rst_tuple_valid", tup_vld, 0);
        chk_counters("t6_rst");
        cyc(pkt[6], 1'b1);
        cyc(pkt[7], 1'b1);
        drain();
        chk("t6_partial_count", log_dat.size() - base, 1);
        make_pkt(8, 12'd112, 12'd64, 16'hff03, 10);
        model_pkt(pkt);
        expect_pkt();
        base = log_dat.size();
        send_words(pkt, -1, 0);
        drain();
        chk("t6_after_count", log_dat.size() - base, 5);
        chk_counters("t6");

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
